// File: rtl/pad_io_ctrl_pkg.sv
// Shared types for the pad control block. Defining PAD_IO_CTRL_LOOPBACK_EN
// adds a per-pad lb_en configuration bit.
package pad_io_ctrl_pkg;

`ifdef PAD_IO_CTRL_LOOPBACK_EN
    typedef struct packed {
        logic lb_en;
        logic filt_en;
        logic pd_en;
        logic ie;
        logic oe;
    } pad_cfg_t;

    localparam int CFG_DATA_W = 5;
    localparam pad_cfg_t PAD_CFG_RST = '{lb_en: 1'b0, filt_en: 1'b0, pd_en: 1'b1, ie: 1'b0, oe: 1'b0};
`else
    typedef struct packed {
        logic filt_en;
        logic pd_en;
        logic ie;
        logic oe;
    } pad_cfg_t;

    localparam int CFG_DATA_W = 4;
    localparam pad_cfg_t PAD_CFG_RST = '{filt_en: 1'b0, pd_en: 1'b1, ie: 1'b0, oe: 1'b0};
`endif

endpackage

// File: rtl/pad_io_ctrl_if.sv
// Configuration write port: valid/ready handshake carrying a pad index and cfg word.
interface pad_io_ctrl_if #(
    parameter int NUM_PADS = 8
);
    import pad_io_ctrl_pkg::*;

    localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic                  cfg_valid_i;
    logic                  cfg_ready_o;
    logic [IDX_W-1:0]      cfg_idx_i;
    logic [CFG_DATA_W-1:0] cfg_data_i;

    modport master (
        output cfg_valid_i, cfg_idx_i, cfg_data_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i, cfg_idx_i, cfg_data_i,
        output cfg_ready_o
    );

endinterface

// File: rtl/pad_in_filter.sv
// One pad input channel: synchroniser, optional stability filter, edge pulses
// and a sticky event status bit.
module pad_in_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int FILT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic filt_en,
    input  logic cnt_clr,
    input  logic evt_clr,
    output logic pad_in,
    output logic rise,
    output logic fall,
    output logic evt_status
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic                   in_d;

    assign s = sync_q[SYNC_STAGES-1];

    // The counter tracks how long s has disagreed with pad_in; any agreement restarts it.
    always_comb begin
        in_d  = pad_in;
        cnt_d = '0;
        if (!cnt_clr) begin
            if (!filt_en) begin
                in_d = s;
            end else if (s != pad_in) begin
                if (cnt_q == FILT_W'(FILT_CYCLES - 1))
                    in_d = s;
                else
                    cnt_d = cnt_q + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            pad_in     <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            evt_status <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
            cnt_q      <= cnt_d;
            pad_in     <= in_d;
            rise       <= in_d & ~pad_in;
            fall       <= ~in_d & pad_in;
            // A new edge beats a same-cycle clear so no event is lost.
            evt_status <= (rise | fall) ? 1'b1 : (evt_status & ~evt_clr);
        end
    end

endmodule

// File: rtl/pad_io_ctrl.sv
// Per-pad run-time configured pad control: cfg registers, output drive and
// filtered/edge-detected inputs. PAD_IO_CTRL_LOOPBACK_EN enables internal loopback.
module pad_io_ctrl
    import pad_io_ctrl_pkg::*;
#(
    parameter int NUM_PADS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int FILT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    pad_io_ctrl_if.slave        cfg,
    input  logic [NUM_PADS-1:0] pad_out_i,
    output logic [NUM_PADS-1:0] pad_I_o,
    output logic [NUM_PADS-1:0] pad_OEN_o,
    output logic [NUM_PADS-1:0] pad_IE_o,
    output logic [NUM_PADS-1:0] pad_PD_o,
    input  logic [NUM_PADS-1:0] pad_O_i,
    output logic [NUM_PADS-1:0] pad_in_o,
    output logic [NUM_PADS-1:0] rise_o,
    output logic [NUM_PADS-1:0] fall_o,
    output logic [NUM_PADS-1:0] evt_status_o,
    input  logic [NUM_PADS-1:0] evt_clr_i
);

    pad_cfg_t            cfg_q [NUM_PADS];
    logic                ready_q;
    logic                accept;
    logic [NUM_PADS-1:0] cfg_wr;

    assign cfg.cfg_ready_o = ready_q;
    assign accept          = cfg.cfg_valid_i & ready_q;

    // Out-of-range indices match no pad, so the write is consumed without effect.
    always_comb begin
        cfg_wr = '0;
        for (int i = 0; i < NUM_PADS; i++)
            cfg_wr[i] = accept && (int'(cfg.cfg_idx_i) == i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            pad_I_o <= '0;
            for (int i = 0; i < NUM_PADS; i++)
                cfg_q[i] <= PAD_CFG_RST;
        end else begin
            ready_q <= ~accept;
            pad_I_o <= pad_out_i;
            for (int i = 0; i < NUM_PADS; i++)
                if (cfg_wr[i])
                    cfg_q[i] <= pad_cfg_t'(cfg.cfg_data_i);
        end
    end

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        logic din;

`ifdef PAD_IO_CTRL_LOOPBACK_EN
        assign din = cfg_q[g].lb_en ? (pad_I_o[g] & cfg_q[g].oe) : (pad_O_i[g] & cfg_q[g].ie);
`else
        assign din = pad_O_i[g] & cfg_q[g].ie;
`endif

        assign pad_OEN_o[g] = ~cfg_q[g].oe;
        assign pad_IE_o[g]  = cfg_q[g].ie;
        assign pad_PD_o[g]  = cfg_q[g].pd_en;

        pad_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .FILT_W      (FILT_W)
        ) u_filt (
            .clk        (clk),
            .rst        (rst),
            .din        (din),
            .filt_en    (cfg_q[g].filt_en),
            .cnt_clr    (cfg_wr[g]),
            .evt_clr    (evt_clr_i[g]),
            .pad_in     (pad_in_o[g]),
            .rise       (rise_o[g]),
            .fall       (fall_o[g]),
            .evt_status (evt_status_o[g])
        );
    end

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Self-checking bench for pad_io_ctrl: table-driven cfg writes, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_pad_io_ctrl;
    import pad_io_ctrl_pkg::*;

    localparam int NP = 6;
    localparam int SS = 2;
    localparam int FC = 4;
    localparam int FW = 4;
    localparam int IW = $clog2(NP);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pad_io_ctrl_if #(.NUM_PADS(NP)) cfg_if ();

    logic [NP-1:0] pad_out, pad_I, pad_OEN, pad_IE, pad_PD, pad_O, pad_in, rise, fall, evt, evt_clr;

    pad_io_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(SS), .FILT_CYCLES(FC), .FILT_W(FW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (cfg_if),
        .pad_out_i    (pad_out),
        .pad_I_o      (pad_I),
        .pad_OEN_o    (pad_OEN),
        .pad_IE_o     (pad_IE),
        .pad_PD_o     (pad_PD),
        .pad_O_i      (pad_O),
        .pad_in_o     (pad_in),
        .rise_o       (rise),
        .fall_o       (fall),
        .evt_status_o (evt),
        .evt_clr_i    (evt_clr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: cfg word {lb,filt,pd,ie,oe}, a delay line of gated inputs,
    // and a per-pad run length of disagreement with the filtered value.
    logic [4:0]    m_cfg [NP];
    logic          m_ready;
    logic [NP-1:0] m_I, m_in, m_rise, m_fall, m_evt;
    logic [NP-1:0] m_hist [SS];
    int            m_run [NP];

    task automatic model_step();
        logic [NP-1:0] gated, s, nin;
        logic acc;
        int   idx;
        if (rst) begin
            m_ready = 1'b0;
            m_I = '0; m_in = '0; m_rise = '0; m_fall = '0; m_evt = '0;
            for (int k = 0; k < SS; k++) m_hist[k] = '0;
            for (int i = 0; i < NP; i++) begin m_cfg[i] = 5'b00100; m_run[i] = 0; end
        end else begin
            acc = cfg_if.cfg_valid_i && m_ready;
            idx = int'(cfg_if.cfg_idx_i);
            s   = m_hist[SS-1];
            for (int i = 0; i < NP; i++) begin
                gated[i] = m_cfg[i][4] ? (m_I[i] & m_cfg[i][0]) : (pad_O[i] & m_cfg[i][1]);
                nin[i]   = m_in[i];
                if (acc && idx == i) m_run[i] = 0;
                else if (!m_cfg[i][3]) begin nin[i] = s[i]; m_run[i] = 0; end
                else if (s[i] == m_in[i]) m_run[i] = 0;
                else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == FC) begin nin[i] = s[i]; m_run[i] = 0; end
                end
                m_evt[i] = (m_rise[i] | m_fall[i]) ? 1'b1 : (m_evt[i] & ~evt_clr[i]);
            end
            m_rise = nin & ~m_in;
            m_fall = ~nin & m_in;
            m_in   = nin;
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = gated;
            m_I = pad_out;
            if (acc && idx < NP) m_cfg[idx] = 5'(cfg_if.cfg_data_i);
            m_ready = !acc;
        end
    endtask

    task automatic cycle();
        logic [NP-1:0] e_oen, e_ie, e_pd;
        model_step();
        @(posedge clk);
        #2;
        for (int i = 0; i < NP; i++) begin
            e_oen[i] = ~m_cfg[i][0];
            e_ie[i]  = m_cfg[i][1];
            e_pd[i]  = m_cfg[i][2];
        end
        chk("m_ready",  cfg_if.cfg_ready_o, m_ready);
        chk("m_pad_I",  pad_I,   m_I);
        chk("m_OEN",    pad_OEN, e_oen);
        chk("m_IE",     pad_IE,  e_ie);
        chk("m_PD",     pad_PD,  e_pd);
        chk("m_pad_in", pad_in,  m_in);
        chk("m_rise",   rise,    m_rise);
        chk("m_fall",   fall,    m_fall);
        chk("m_evt",    evt,     m_evt);
    endtask

    task automatic cfg_write(input int idx, input logic [CFG_DATA_W-1:0] d);
        logic done;
        done = 1'b0;
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_idx_i   = IW'(idx);
        cfg_if.cfg_data_i  = d;
        for (int t = 0; t < 8 && !done; t++) begin
            done = cfg_if.cfg_ready_o;
            cycle();
        end
        chk("cfg_accept_timeout", done, 1'b1);
        cfg_if.cfg_valid_i = 1'b0;
    endtask

    typedef struct {
        int         idx;
        logic [3:0] d;
        logic       oen;
        logic       ie;
        logic       pd;
    } vec_t;

    vec_t vt [6];

    initial begin
        logic seen;
        int   n;
        vt[0] = '{0, 4'b0000, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1, 4'b0101, 1'b0, 1'b0, 1'b1};
        vt[2] = '{3, 4'b0010, 1'b1, 1'b1, 1'b0};
        vt[3] = '{4, 4'b1111, 1'b0, 1'b1, 1'b1};
        vt[4] = '{5, 4'b0100, 1'b1, 1'b0, 1'b1};
        vt[5] = '{0, 4'b0011, 1'b0, 1'b1, 1'b0};

        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_idx_i   = '0;
        cfg_if.cfg_data_i  = '0;
        pad_out = '0; pad_O = '0; evt_clr = '0;

        // Reset values
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("rst_ready", cfg_if.cfg_ready_o, 1'b0);
            chk("rst_oen",   pad_OEN, {NP{1'b1}});
            chk("rst_pd",    pad_PD,  {NP{1'b1}});
            chk("rst_ie",    pad_IE,  '0);
            chk("rst_evt",   evt,     '0);
        end
        rst = 1'b0;
        cycle();
        chk("ready_after_rst", cfg_if.cfg_ready_o, 1'b1);

        // Held valid: back-to-back writes land every other cycle
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_idx_i   = IW'(2);
        cfg_if.cfg_data_i  = CFG_DATA_W'(4'b0011);
        cycle();
        chk("hs_ready_drop", cfg_if.cfg_ready_o, 1'b0);
        chk("hs_oen2", pad_OEN[2], 1'b0);
        chk("hs_ie2",  pad_IE[2],  1'b1);
        cfg_if.cfg_idx_i = IW'(3);
        cycle();
        chk("hs_ready_back", cfg_if.cfg_ready_o, 1'b1);
        chk("hs_oen3_wait",  pad_OEN[3], 1'b1);
        cycle();
        chk("hs_oen3_taken", pad_OEN[3], 1'b0);
        cfg_if.cfg_idx_i  = IW'(NP);
        cfg_if.cfg_data_i = CFG_DATA_W'(4'b1111);
        cycle();
        cycle();
        chk("oor_ready_drop", cfg_if.cfg_ready_o, 1'b0);
        chk("oor_oen", pad_OEN, 6'b110011);
        chk("oor_ie",  pad_IE,  6'b001100);
        chk("oor_pd",  pad_PD,  6'b110011);
        cfg_if.cfg_valid_i = 1'b0;
        cycle();

        // Table of cfg writes and resulting pad controls
        for (int v = 0; v < 6; v++) begin
            cfg_write(vt[v].idx, CFG_DATA_W'(vt[v].d));
            chk("tbl_oen", pad_OEN[vt[v].idx], vt[v].oen);
            chk("tbl_ie",  pad_IE[vt[v].idx],  vt[v].ie);
            chk("tbl_pd",  pad_PD[vt[v].idx],  vt[v].pd);
        end

        // Unfiltered path on pad 2: 3-cycle latency
        pad_O[2] = 1'b1;
        cycle(); chk("unf_c1", pad_in[2], 1'b0);
        cycle(); chk("unf_c2", pad_in[2], 1'b0);
        cycle(); chk("unf_c3", pad_in[2], 1'b1); chk("unf_rise", rise[2], 1'b1);
        cycle(); chk("unf_rise_end", rise[2], 1'b0); chk("unf_evt", evt[2], 1'b1);

        // Filtered fall latency
        cfg_write(2, CFG_DATA_W'(4'b1011));
        pad_O[2] = 1'b0;
        n = 0;
        while (pad_in[2] && n < 12) begin cycle(); n++; end
        chk("filt_fall_latency", n, 6);
        cycle(); cycle();
        evt_clr[2] = 1'b1; cycle(); evt_clr[2] = 1'b0;
        chk("clr_alone", evt[2], 1'b0);

        // Short high glitch must not pass
        pad_O[2] = 1'b1;
        cycle(); cycle(); cycle();
        pad_O[2] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            seen = seen | pad_in[2] | rise[2];
        end
        chk("glitch_blocked", seen, 1'b0);

        // Six-cycle high passes at cycle 6
        pad_O[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            if (k == 5) chk("filt_c5", pad_in[2], 1'b0);
        end
        chk("filt_c6", pad_in[2], 1'b1);
        chk("filt_rise", rise[2], 1'b1);
        pad_O[2] = 1'b0;
        cycle();
        evt_clr[2] = 1'b1; cycle(); evt_clr[2] = 1'b0;
        chk("clr_before_fall", evt[2], 1'b0);
        n = 0;
        while (!fall[2] && n < 12) begin cycle(); n++; end
        chk("fall_seen", fall[2], 1'b1);
        evt_clr[2] = 1'b1;
        cycle(); chk("set_wins", evt[2], 1'b1);
        cycle(); chk("clr_after", evt[2], 1'b0);
        evt_clr[2] = 1'b0;

`ifdef PAD_IO_CTRL_LOOPBACK_EN
        // Loopback: pad 5 follows pad_out_i with pad_O_i forced opposite
        cfg_write(5, 5'b10001);
        pad_O[5] = 1'b0;
        pad_out[5] = 1'b1;
        cycle(); cycle(); cycle();
        chk("lb_c3", pad_in[5], 1'b0);
        cycle();
        chk("lb_c4", pad_in[5], 1'b1);
        pad_O[5] = 1'b1;
        pad_out[5] = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        chk("lb_fall", pad_in[5], 1'b0);
`endif

        // Randomized traffic with a mid-run reset
        for (int c = 0; c < 600; c++) begin
            rst = (c >= 300 && c < 302);
            pad_O   = NP'($urandom);
            pad_out = NP'($urandom);
            evt_clr = NP'($urandom & $urandom & $urandom);
            cfg_if.cfg_valid_i = ($urandom_range(0, 2) == 0);
            cfg_if.cfg_idx_i   = IW'($urandom_range(0, 7));
            cfg_if.cfg_data_i  = CFG_DATA_W'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
